// File: rtl/ps2_line_assembler_if.sv
// rtl/ps2_line_assembler_if.sv - PS/2 scan-code in, committed/edited text line out
//
// Signals:
//   ps2_key_data     scan-code byte from the PS/2 receiver
//   ps2_key_pressed  one-cycle strobe qualifying ps2_key_data
//   ps2_line_content last committed line, char i at [8i+7:8i]
//   ps2_line_ready   one-cycle pulse when ps2_line_content was just updated
//   line_edit        live edit buffer, same packing as ps2_line_content
//   cursor           number of chars in the edit buffer, 0..LINE_CHARS
// master = key byte producer / line consumer, slave = the assembler.
interface ps2_line_assembler_if #(
    parameter int LINE_CHARS = 32
);
    localparam int CW = $clog2(LINE_CHARS + 1);

    logic [7:0]              ps2_key_data;
    logic                    ps2_key_pressed;
    logic [8*LINE_CHARS-1:0] ps2_line_content;
    logic                    ps2_line_ready;
    logic [8*LINE_CHARS-1:0] line_edit;
    logic [CW-1:0]           cursor;

    modport master (
        output ps2_key_data,
        output ps2_key_pressed,
        input  ps2_line_content,
        input  ps2_line_ready,
        input  line_edit,
        input  cursor
    );

    modport slave (
        input  ps2_key_data,
        input  ps2_key_pressed,
        output ps2_line_content,
        output ps2_line_ready,
        output line_edit,
        output cursor
    );
endinterface

// File: rtl/ps2_line_assembler.sv
// rtl/ps2_line_assembler.sv - PS/2 Set-2 scan codes to committed ASCII text lines
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    ps2_line_assembler_if.slave: key byte/strobe in; committed line,
//          ready pulse, live edit buffer and cursor out.
// Decodes make/break/extended prefixes, keeps an editable line with backspace,
// and commits the line on Enter (main or keypad) with a one-cycle ready pulse.
module ps2_line_assembler #(
    parameter int LINE_CHARS = 32
) (
    input  logic               clock,
    input  logic               reset,
    ps2_line_assembler_if.slave bus
);
    localparam int CW = $clog2(LINE_CHARS + 1);
    localparam int LW = 8 * LINE_CHARS;

    // Decoder states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // Action kinds for a make code
    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_CHAR  = 2'd1;
    localparam logic [1:0] K_BS    = 2'd2;
    localparam logic [1:0] K_ENTER = 2'd3;

    // Returns {kind, ascii}; ascii is only meaningful for K_CHAR.
    function automatic logic [9:0] decode(input logic [7:0] sc);
        logic [9:0] r;
        r = {K_NONE, 8'h00};
        case (sc)
            8'h1C: r = {K_CHAR, 8'h41};  8'h32: r = {K_CHAR, 8'h42};
            8'h21: r = {K_CHAR, 8'h43};  8'h23: r = {K_CHAR, 8'h44};
            8'h24: r = {K_CHAR, 8'h45};  8'h2B: r = {K_CHAR, 8'h46};
            8'h34: r = {K_CHAR, 8'h47};  8'h33: r = {K_CHAR, 8'h48};
            8'h43: r = {K_CHAR, 8'h49};  8'h3B: r = {K_CHAR, 8'h4A};
            8'h42: r = {K_CHAR, 8'h4B};  8'h4B: r = {K_CHAR, 8'h4C};
            8'h3A: r = {K_CHAR, 8'h4D};  8'h31: r = {K_CHAR, 8'h4E};
            8'h44: r = {K_CHAR, 8'h4F};  8'h4D: r = {K_CHAR, 8'h50};
            8'h15: r = {K_CHAR, 8'h51};  8'h2D: r = {K_CHAR, 8'h52};
            8'h1B: r = {K_CHAR, 8'h53};  8'h2C: r = {K_CHAR, 8'h54};
            8'h3C: r = {K_CHAR, 8'h55};  8'h2A: r = {K_CHAR, 8'h56};
            8'h1D: r = {K_CHAR, 8'h57};  8'h22: r = {K_CHAR, 8'h58};
            8'h35: r = {K_CHAR, 8'h59};  8'h1A: r = {K_CHAR, 8'h5A};
            8'h45: r = {K_CHAR, 8'h30};  8'h16: r = {K_CHAR, 8'h31};
            8'h1E: r = {K_CHAR, 8'h32};  8'h26: r = {K_CHAR, 8'h33};
            8'h25: r = {K_CHAR, 8'h34};  8'h2E: r = {K_CHAR, 8'h35};
            8'h36: r = {K_CHAR, 8'h36};  8'h3D: r = {K_CHAR, 8'h37};
            8'h3E: r = {K_CHAR, 8'h38};  8'h46: r = {K_CHAR, 8'h39};
            8'h29: r = {K_CHAR, 8'h20};  8'h4E: r = {K_CHAR, 8'h2D};
            8'h49: r = {K_CHAR, 8'h2E};  8'h41: r = {K_CHAR, 8'h2C};
            8'h66: r = {K_BS,   8'h00};
            8'h5A: r = {K_ENTER, 8'h00};
            default: r = {K_NONE, 8'h00};
        endcase
        return r;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] edit_q, edit_d;
    logic [LW-1:0] content_q, content_d;
    logic          ready_q, ready_d;
    logic [CW-1:0] cur_q, cur_d;

    logic [1:0]    kind;
    logic [7:0]    ch;
    logic [CW-1:0] cur_m1;
    logic          do_char, do_bs, do_enter;

    always_comb begin
        state_d   = state_q;
        edit_d    = edit_q;
        content_d = content_q;
        ready_d   = 1'b0;
        cur_d     = cur_q;
        {kind, ch} = decode(bus.ps2_key_data);
        cur_m1    = cur_q - CW'(1);
        do_char   = 1'b0;
        do_bs     = 1'b0;
        do_enter  = 1'b0;

        if (bus.ps2_key_pressed) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ps2_key_data == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (bus.ps2_key_data == 8'hE0) begin
                        state_d = ST_EXT;
                    end else begin
                        do_char  = (kind == K_CHAR);
                        do_bs    = (kind == K_BS);
                        do_enter = (kind == K_ENTER);
                    end
                end
                ST_EXT: begin
                    if (bus.ps2_key_data == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        // Only keypad Enter is meaningful among extended keys.
                        state_d  = ST_IDLE;
                        do_enter = (bus.ps2_key_data == 8'h5A);
                    end
                end
                // BRK / EXT_BRK: the released key's code is swallowed.
                default: state_d = ST_IDLE;
            endcase
        end

        if (do_char && (cur_q < CW'(LINE_CHARS))) begin
            edit_d[{cur_q, 3'b000} +: 8] = ch;
            cur_d = cur_q + CW'(1);
        end

        if (do_bs && (cur_q != '0)) begin
            edit_d[{cur_m1, 3'b000} +: 8] = 8'h00;
            cur_d = cur_m1;
        end

        // An empty line is never committed, so consumers only see real text.
        if (do_enter && (cur_q != '0)) begin
            content_d = edit_q;
            ready_d   = 1'b1;
            edit_d    = '0;
            cur_d     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            edit_q    <= '0;
            content_q <= '0;
            ready_q   <= 1'b0;
            cur_q     <= '0;
        end else begin
            state_q   <= state_d;
            edit_q    <= edit_d;
            content_q <= content_d;
            ready_q   <= ready_d;
            cur_q     <= cur_d;
        end
    end

    assign bus.ps2_line_content = content_q;
    assign bus.ps2_line_ready   = ready_q;
    assign bus.line_edit        = edit_q;
    assign bus.cursor           = cur_q;
endmodule

// File: tb/tb_ps2_line_assembler.sv
// tb/tb_ps2_line_assembler.sv - directed self-checking bench for ps2_line_assembler
module tb_ps2_line_assembler;
    logic clock;
    logic reset;
    int   errors;
    int   checks;
    int   pulses;
    logic clr_pulses;

    ps2_line_assembler_if #(.LINE_CHARS(32)) bus ();

    ps2_line_assembler #(.LINE_CHARS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts ready pulses; each high cycle is seen at the following edge.
    always @(posedge clock) begin
        if (clr_pulses) pulses <= 0;
        else if (bus.ps2_line_ready) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe one byte; returns #1 after the sampling edge. Consecutive calls
    // keep ps2_key_pressed high across edges (back-to-back strobes).
    task automatic send(input logic [7:0] b);
        bus.ps2_key_data    = b;
        bus.ps2_key_pressed = 1'b1;
        @(posedge clock);
        #1;
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_key_data    = 8'hXX;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_pulses();
        clr_pulses = 1'b1;
        @(posedge clock);
        #1;
        clr_pulses = 1'b0;
    endtask

    logic [7:0] seq1 [7] = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32, 8'h5A};
    logic [7:0] seq2 [5] = '{8'h16, 8'h1E, 8'h66, 8'h26, 8'h5A};
    int         cur2 [5] = '{1, 2, 1, 2, 0};
    logic [7:0] seq3 [6] = '{8'h4E, 8'h12, 8'h49, 8'h41, 8'h45, 8'h3D};

    initial begin
        errors = 0;
        checks = 0;
        clr_pulses = 1'b1;
        reset = 1'b1;
        bus.ps2_key_data = 8'h00;
        bus.ps2_key_pressed = 1'b0;
        idle(2);
        reset = 1'b0;
        clr_pulses = 1'b0;

        // Reset state
        check("rst_content", bus.ps2_line_content, 256'h0);
        check("rst_ready",   256'(bus.ps2_line_ready), 256'h0);
        check("rst_edit",    bus.line_edit, 256'h0);
        check("rst_cursor",  256'(bus.cursor), 256'h0);

        // "AB" with break codes interleaved
        for (int i = 0; i < 7; i++) send(seq1[i]);
        check("ab_ready",   256'(bus.ps2_line_ready), 256'h1);
        check("ab_content", bus.ps2_line_content, 256'h4241);
        check("ab_cursor",  256'(bus.cursor), 256'h0);
        check("ab_edit",    bus.line_edit, 256'h0);
        idle(1);
        check("ab_ready_low", 256'(bus.ps2_line_ready), 256'h0);
        check("ab_pulses",    256'(pulses), 256'h1);
        clear_pulses();

        // Backspace editing: "12" <bs> "3" -> "13"
        for (int i = 0; i < 5; i++) begin
            send(seq2[i]);
            check($sformatf("bs_cursor%0d", i), 256'(bus.cursor), 256'(cur2[i]));
        end
        check("bs_content", bus.ps2_line_content, 256'h3331);

        // Saturation: 40 spaces, only 32 kept
        for (int i = 0; i < 40; i++) send(8'h29);
        check("sat_cursor", 256'(bus.cursor), 256'd32);
        check("sat_edit",   bus.line_edit, {32{8'h20}});
        clear_pulses();
        send(8'h5A);
        idle(1);
        check("sat_content", bus.ps2_line_content, {32{8'h20}});
        check("sat_pulses",  256'(pulses), 256'h1);
        clear_pulses();

        // Empty line: backspace and Enter are no-ops
        send(8'h66);
        check("empty_bs_cursor", 256'(bus.cursor), 256'h0);
        send(8'h5A);
        check("empty_ready", 256'(bus.ps2_line_ready), 256'h0);
        idle(1);
        check("empty_pulses",  256'(pulses), 256'h0);
        check("empty_content", bus.ps2_line_content, {32{8'h20}});

        // Extended keys discarded; break of Enter ignored; keypad Enter commits
        send(8'h1C);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h5A);
        check("ext_cursor", 256'(bus.cursor), 256'h1);
        check("ext_edit",   bus.line_edit, 256'h41);
        check("ext_no_commit", bus.ps2_line_content, {32{8'h20}});
        send(8'hE0); send(8'h5A);
        check("kp_ready",   256'(bus.ps2_line_ready), 256'h1);
        check("kp_content", bus.ps2_line_content, 256'h41);
        check("kp_cursor",  256'(bus.cursor), 256'h0);

        // Punctuation/digits with a shift make code in the middle
        for (int i = 0; i < 6; i++) send(seq3[i]);
        check("punct_cursor", 256'(bus.cursor), 256'd5);
        check("punct_edit",   bus.line_edit, 256'h37302C2E2D);
        send(8'h5A);
        check("punct_content", bus.ps2_line_content, 256'h37302C2E2D);

        // Back-to-back strobes (typematic repeat)
        send(8'h1C); send(8'h1C); send(8'h5A);
        check("b2b_content", bus.ps2_line_content, 256'h4141);
        idle(1);
        clear_pulses();

        // Reset mid-line
        send(8'h2C); send(8'h2C);
        check("pre_rst_edit", bus.line_edit, 256'h5454);
        do_reset();
        check("mid_rst_edit",    bus.line_edit, 256'h0);
        check("mid_rst_cursor",  256'(bus.cursor), 256'h0);
        check("mid_rst_content", bus.ps2_line_content, 256'h0);
        idle(3);
        check("mid_rst_pulses",  256'(pulses), 256'h0);

        // Reset clears a pending break prefix
        send(8'hF0);
        do_reset();
        send(8'h1C);
        check("prefix_rst_cursor", 256'(bus.cursor), 256'h1);
        check("prefix_rst_edit",   bus.line_edit, 256'h41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_line_assembler.md
# ps2_line_assembler

Turns the PS/2 keyboard scan-code byte stream into committed 32-character ASCII text lines. It is the producer for the display controller's `ps2_line_content` / `ps2_line_ready` input pair, which the screen character writer renders. It decodes Set-2 make/break/extended prefixes and keeps an editable line buffer with cursor and backspace. On Enter it commits the line with a one-cycle ready pulse.

## Interface
- `LINE_CHARS`, 32 — characters per line; content width is 8*LINE_CHARS (256 at default).
- `clock`  in  1  — system clock, the same clock that drives the display controller's control side.
- `reset`  in  1  — synchronous, active-high.
- `ps2_key_data`  in  8  — received scan-code byte from the PS/2 receiver.
- `ps2_key_pressed`  in  1  — one-cycle strobe: `ps2_key_data` is valid.
- `ps2_line_content`  out  256  — last committed line; char i at bits [8i+7:8i]; unused chars 8'h00.
- `ps2_line_ready`  out  1  — one-cycle pulse when `ps2_line_content` has just been updated.
- `line_edit`  out  256  — live edit buffer, same packing, for echo.
- `cursor`  out  6  — number of chars in the edit buffer, 0..32.

## Operation
- Decoder FSM states:
  - IDLE: byte F0 -> BRK; E0 -> EXT; any other byte is a make code -> process, stay IDLE.
  - BRK: the next byte is discarded -> IDLE.
  - EXT: F0 -> EXT_BRK; 5A (keypad Enter) -> Enter action, then IDLE; any other byte is discarded -> IDLE.
  - EXT_BRK: the next byte is discarded -> IDLE.
- Make-code map (letters are always uppercase, no shift tracking):
  - Letters:
    - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34
    - H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31
    - O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C
    - V 2A, W 1D, X 22, Y 35, Z 1A
  - Digits: 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46.
  - Punctuation: space 29 -> 8'h20; minus 4E -> 8'h2D; period 49 -> 8'h2E; comma 41 -> 8'h2C.
  - Control: backspace 66; Enter 5A.
  - All other make codes, including shift 12/59, are ignored.
- Printable char: if `cursor` < 32, write it to slot `cursor` and increment `cursor`. If `cursor` == 32, drop the char with no state change.
- Backspace: if `cursor` > 0, decrement `cursor` and clear slot `cursor-1` to 00. If `cursor` == 0, no-op.
- Enter:
  - `cursor` > 0: copy `line_edit` to `ps2_line_content`, pulse `ps2_line_ready`, clear `line_edit` to all-zero, set `cursor` to 0.
  - `cursor` == 0: ignored — no pulse, content unchanged.
- Typematic repeats (repeated make codes without a break) are each processed as a new keypress.

## Timing
- Reset values: `ps2_line_content`=0, `ps2_line_ready`=0, `line_edit`=0, `cursor`=0, FSM=IDLE.
- Reset applies on the rising edge of `clock`. A reset mid-line discards the partial line and any pending prefix state.
- All effects appear on the clock edge that samples `ps2_key_pressed`=1: latency 1 cycle from strobe to visible output change.
- `ps2_line_ready` is high for exactly one cycle. `ps2_line_content` is valid in that cycle and held until the next commit.
- Strobes may arrive on consecutive cycles; each is fully processed, and none are lost.
- Bytes are sampled only when `ps2_key_pressed`=1. `ps2_key_data` is don't-care otherwise.

## Test plan
- Reset, then send 1C,F0,1C,32,F0,32,5A -> after the 5A strobe edge: `ps2_line_ready` pulses once; `ps2_line_content`[15:0]=16'h4241, upper bits 0; `cursor`=0; `line_edit`=0.
- Send 16,1E,66,26,5A -> committed content [15:0]=16'h3331 ("13"); `cursor` sequence 1,2,1,2,0.
- Send 40 make codes of 29 with no breaks, then 5A -> all 32 slots = 8'h20, `cursor` saturates at 32, one ready pulse.
- At `cursor`=0, send 66 then 5A -> no pulse, `cursor` stays 0, content unchanged.
- Send E0,75 then E0,F0,75 then E0,5A with one char buffered -> the arrow key's bytes are discarded, and the keypad Enter commits the buffered char.
- Send 1C,1C with strobes on back-to-back cycles, then 5A -> content [15:0]=16'h4141. Assert `reset` after 2C,2C -> `line_edit`=0, `cursor`=0, and no spurious `ps2_line_ready` follows.
